// File: rtl/demux_sched_pkg.sv
// Shared channel geometry, FSM state type and burst counter width for the burst scheduler.
// Channel count is fixed at four; the one-hot helper builds the per-channel valid vector.
package demux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin target picker: stays on ptr when allowed, else first enabled channel after ptr.
// Latency: purely combinational. Backpressure: none (found=0 when no channel is enabled).
// The search includes ptr itself last, so a lone enabled channel always wins.
module rr_pick
    import demux_sched_pkg::*;
(
    input  logic [CH_W-1:0]   ptr,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              keep,
    output logic [CH_W-1:0]   target,
    output logic              found
);

    logic [CH_W-1:0] idx;

    always_comb begin
        target = ptr;
        idx    = '0;
        found  = |ch_en;
        if (!(keep && ch_en[ptr])) begin
            // Walk offsets from farthest to nearest so the nearest enabled channel wins.
            for (int i = NUM_CH; i >= 1; i--) begin
                idx = ptr + CH_W'(i);
                if (ch_en[idx]) begin
                    target = idx;
                end
            end
        end
    end

endmodule

// File: rtl/demux_burst_scheduler.sv
// Single-beat holding stage that routes each beat to one of four channels in bursts of up to BURST.
// Latency: 1 cycle from acceptance to dout_valid; sustains 1 beat/cycle when the owner drains.
// Backpressure: din_ready drops while the owner stalls or when no channel is enabled.
module demux_burst_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] dout_ready,
    output logic [NUM_CH-1:0] dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic [CH_W-1:0]   sel,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] dat_q,   dat_d;
    logic [CH_W-1:0]   sel_q,   sel_d;
    logic [NUM_CH-1:0] vld_q,   vld_d;
    logic [CH_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic            keep;
    logic [CH_W-1:0] pick_tgt;
    logic            pick_found;
    logic            drain;
    logic            accept;

    // cnt_q==0 means nothing granted yet, so the first beat never sticks to the reset ptr.
    assign keep = (cnt_q != '0) && (cnt_q < CNT_W'(BURST));

    rr_pick u_pick (
        .ptr    (ptr_q),
        .ch_en  (ch_en),
        .keep   (keep),
        .target (pick_tgt),
        .found  (pick_found)
    );

    assign drain     = (state_q == ST_HOLD) && dout_ready[sel_q];
    assign din_ready = rst_n && ((state_q == ST_EMPTY) || dout_ready[sel_q]) && pick_found;
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ST_HOLD;
            dat_d   = din;
            sel_d   = pick_tgt;
            vld_d   = onehot(pick_tgt);
            ptr_d   = pick_tgt;
            cnt_d   = (keep && ch_en[ptr_q]) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        end else if (drain) begin
            state_d = ST_EMPTY;
            vld_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            dat_q   <= '0;
            sel_q   <= '0;
            vld_q   <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout       = dat_q;
    assign sel        = sel_q;
    assign dout_valid = vld_q;
    assign busy       = (state_q == ST_HOLD);

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Directed bench for demux_burst_scheduler: hand-computed channel sequences, stalls,
// enable drop-out and mid-hold reset, each checked with an immediate assertion.
module tb_demux_burst_scheduler;

    logic       clk;
    logic       rst_n;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;
    logic [3:0] ch_en;
    logic [3:0] dout_ready;
    logic [3:0] dout_valid;
    logic [7:0] dout;
    logic [1:0] sel;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    demux_burst_scheduler #(.DATA_W(8), .BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .ch_en      (ch_en),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .sel        (sel),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_sel;
        logic [3:0] exp_vld;
        logic [1:0] seq_b [6];

        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        ch_en      = '0;
        dout_ready = '0;
        seq_b      = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};

        // Reset state
        #12;
        chk("rst_vld",   dout_valid, 4'b0000);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_sel",   sel,        2'd0);
        chk("rst_dout",  dout,       8'h00);
        chk("rst_ready", din_ready,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // All channels enabled, continuous stream: bursts of four per channel
        ch_en      = 4'b1111;
        dout_ready = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din       = 8'(k);
            #1 chk("a_ready", din_ready, 1'b1);
            @(posedge clk);
            #1;
            exp_sel = 2'(k / 4);
            exp_vld = 4'b0001 << exp_sel;
            chk("a_sel",  sel,        exp_sel);
            chk("a_dout", dout,       8'(k));
            chk("a_vld",  dout_valid, exp_vld);
        end
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        #1 chk("a_drained", busy, 1'b0);

        // Channels 1 and 3 only
        do_reset();
        ch_en = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din       = 8'(8'h10 + k);
            @(posedge clk);
            #1;
            exp_vld = 4'b0001 << seq_b[k];
            chk("b_sel", sel,        seq_b[k]);
            chk("b_vld", dout_valid, exp_vld);
        end

        // Stalled owner keeps the beat stable
        do_reset();
        ch_en      = 4'b0100;
        dout_ready = 4'b1011;
        @(negedge clk);
        din_valid = 1'b1;
        din       = 8'hA5;
        @(posedge clk);
        #1;
        chk("c_sel", sel, 2'd2);
        chk("c_vld", dout_valid, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            din = 8'h5A;
            #1 chk("c_stall_ready", din_ready, 1'b0);
            @(posedge clk);
            #1;
            chk("c_stall_dout", dout,       8'hA5);
            chk("c_stall_vld",  dout_valid, 4'b0100);
        end
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 4'b1111;
        @(posedge clk);
        #1;
        chk("c_deliv_busy", busy,       1'b0);
        chk("c_deliv_vld",  dout_valid, 4'b0000);
        @(posedge clk);
        #1 chk("c_once", dout_valid, 4'b0000);

        // Enables drop while a beat is held
        do_reset();
        ch_en      = 4'b1111;
        dout_ready = 4'b0000;
        @(negedge clk);
        din_valid = 1'b1;
        din       = 8'h3C;
        @(posedge clk);
        #1 chk("d_sel", sel, 2'd0);
        @(negedge clk);
        din_valid = 1'b0;
        ch_en     = 4'b0000;
        #1 chk("d_ready_off", din_ready, 1'b0);
        @(posedge clk);
        #1 chk("d_held_vld", dout_valid, 4'b0001);
        @(negedge clk);
        dout_ready = 4'b1111;
        #1 chk("d_ready_drain", din_ready, 1'b0);
        @(posedge clk);
        #1 chk("d_delivered", busy, 1'b0);
        @(negedge clk);
        din_valid = 1'b1;
        din       = 8'h77;
        #1 chk("d_ready_none", din_ready, 1'b0);
        @(posedge clk);
        #1 chk("d_no_accept", busy, 1'b0);
        @(negedge clk);
        ch_en = 4'b0010;
        #1 chk("d_ready_back", din_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("d_new_sel",  sel,  2'd1);
        chk("d_new_dout", dout, 8'h77);

        // Reset asserted while holding a beat
        @(negedge clk);
        din_valid  = 1'b1;
        din        = 8'h99;
        dout_ready = 4'b0000;
        @(posedge clk);
        #1 chk("e_pre_busy", busy, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("e_rst_vld",   dout_valid, 4'b0000);
        chk("e_rst_busy",  busy,       1'b0);
        chk("e_rst_ready", din_ready,  1'b0);
        chk("e_rst_dout",  dout,       8'h00);
        @(negedge clk);
        rst_n      = 1'b1;
        ch_en      = 4'b1111;
        dout_ready = 4'b1111;
        din_valid  = 1'b1;
        din        = 8'h42;
        @(posedge clk);
        #1;
        chk("e_first_sel",  sel,  2'd0);
        chk("e_first_dout", dout, 8'h42);

        // Single enabled channel takes every beat without stalls
        do_reset();
        ch_en      = 4'b0001;
        dout_ready = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            din_valid = 1'b1;
            din       = 8'(8'h80 + k);
            #1 chk("f_ready", din_ready, 1'b1);
            @(posedge clk);
            #1;
            chk("f_sel",  sel,  2'd0);
            chk("f_dout", dout, 8'(8'h80 + k));
        end
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/demux_burst_scheduler.md
DEMUX_BURST_SCHEDULER -- requirements
Module: demux_burst_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the data beat.
REQ-002 SHALL have parameter BURST, default 4 (range 1..15): maximum consecutive beats granted to one channel before rotating.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port din_valid, input, 1: upstream beat present.
REQ-006 SHALL have port din, input, DATA_W: upstream beat data.
REQ-007 SHALL have port din_ready, output, 1: scheduler accepts the beat this cycle.
REQ-008 SHALL have port ch_en, input, 4: per-channel enable, sampled only at beat acceptance.
REQ-009 SHALL have port dout_ready, input, 4: per-channel downstream ready.
REQ-010 SHALL have port dout_valid, output, 4: one-hot valid of the held beat (all zeros when empty).
REQ-011 SHALL have port dout, output, DATA_W: held beat data, common to all channels.
REQ-012 SHALL have port sel, output, 2: index of the channel owning the held beat (drives the 1-to-4 demux select).
REQ-013 SHALL have port busy, output, 1: high while a beat is held.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (no held beat), HOLD (one beat registered for channel sel).
REQ-015 SHALL set din_ready = (state==EMPTY || dout_ready[sel]) && (ch_en != 0).
REQ-016 SHALL accept a beat when din_valid && din_ready; the beat is registered into dout/sel and the FSM is in HOLD on the next cycle (1-cycle latency).
REQ-017 SHALL leave HOLD for EMPTY when dout_ready[sel] is high and no new beat is accepted in the same cycle; accept plus drain in one cycle remains in HOLD with the new beat (throughput 1 beat/cycle).
REQ-018 SHALL keep dout, sel, dout_valid stable in HOLD until dout_ready[sel] is high.
REQ-019 SHALL drive dout_valid = one-hot(sel) in HOLD, 4'b0000 in EMPTY; dout_ready of non-selected channels is ignored.
REQ-020 SHALL choose the target channel at acceptance: last granted channel (ptr) if ch_en[ptr] && burst_cnt < BURST, else the first enabled channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4 wrap-around).
REQ-021 SHALL increment burst_cnt on acceptance to the same channel, and set burst_cnt to 1 when the target differs from ptr; ptr updates to the target.
REQ-022 SHALL, with a single enabled channel, grant it every beat (burst_cnt saturates rotation back to itself, resetting to 1).
REQ-023 SHALL, when ch_en is all zeros, hold din_ready low; a beat already held is still delivered.
REQ-024 SHALL not drop or duplicate a held beat when ch_en[sel] deasserts during HOLD.
REQ-025 SHALL allow simultaneous dout_ready[sel] and din_valid to complete both transfers in the same edge.

Reset
REQ-026 SHALL on rst_n low immediately force: state EMPTY, dout_valid 0, dout 0, sel 0, busy 0, ptr 3, burst_cnt 0, so the first grant goes to channel 0.
REQ-027 SHALL discard any held beat when reset asserts mid-operation; din_ready is 0 while rst_n is low.

Structure
REQ-028 SHALL place NUM_CH=4, CH_W=2, the FSM state enum and BURST counter width (4 bits) in shared package demux_sched_pkg.
REQ-029 SHALL use one sub-module rr_pick (inputs ptr, ch_en, keep flag; outputs target index and found flag), purely combinational.

Verification
REQ-030 SHALL cover: reset, ch_en=4'b1111, BURST=4, all dout_ready=1, din_valid continuous with din=0..11 -> sel sequence 0,0,0,0,1,1,1,1,2,2,2,2, one beat per cycle.
REQ-031 SHALL cover: ch_en=4'b1010, 6 beats -> sel 1,1,1,1,3,3; channels 0 and 2 never see dout_valid.
REQ-032 SHALL cover: held beat din=8'hA5 on sel=2, dout_ready[2]=0 for 5 cycles -> dout=8'hA5 and dout_valid=4'b0100 stable, din_ready=0; then dout_ready[2]=1 -> delivered once.
REQ-033 SHALL cover: ch_en goes 0 while beat held -> beat delivered, then din_ready stays 0 until ch_en nonzero.
REQ-034 SHALL cover: rst_n pulsed low while in HOLD -> dout_valid=0 and busy=0 immediately, first post-reset beat goes to sel=0.
REQ-035 SHALL cover: ch_en=4'b0001 for 10 beats -> all beats on sel=0, no stall cycles with dout_ready[0]=1.
